// File: rtl/matmul_scheduler_pkg.sv
// rtl/matmul_scheduler_pkg.sv - shared types and width helpers for the matmul request scheduler
package mm_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  function automatic int cnt_width(input int max_wait);
    return (max_wait > 1) ? $clog2(max_wait) : 1;
  endfunction

  function automatic int idx_width(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

endpackage

// File: rtl/matmul_scheduler_if.sv
// rtl/matmul_scheduler_if.sv - request, datapath and response signals of the matmul scheduler
interface matmul_scheduler_if
  import mm_sched_pkg::*;
#(
  parameter int W     = 16,
  parameter int IN_D  = 4,
  parameter int OUT_D = 8,
  parameter int N_REQ = 4
);
  localparam int IW = idx_width(N_REQ);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*IN_D*W-1:0] req_a;
  logic                    mm_start;
  logic [IN_D*W-1:0]       mm_a;
  logic [2*OUT_D*W-1:0]    mm_out;
  logic                    mm_out_v;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [2*OUT_D*W-1:0]    resp_data;
  logic [IW-1:0]           resp_id;
  logic                    busy;
  logic                    err;

  modport master (
    input  req_valid, req_a, mm_out, mm_out_v, resp_ready,
    output req_ready, mm_start, mm_a, resp_valid, resp_data, resp_id, busy, err
  );

  modport slave (
    output req_valid, req_a, mm_out, mm_out_v, resp_ready,
    input  req_ready, mm_start, mm_a, resp_valid, resp_data, resp_id, busy, err
  );

endinterface

// File: rtl/matmul_scheduler_rr_arbiter.sv
// rtl/matmul_scheduler_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter
  import mm_sched_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]              i_req,
  input  logic [idx_width(N_REQ)-1:0]   i_ptr,
  output logic [N_REQ-1:0]              o_grant,
  output logic [idx_width(N_REQ)-1:0]   o_idx,
  output logic                          o_any
);
  localparam int IW = idx_width(N_REQ);

  logic [IW-1:0] w_j;

  function automatic logic [IW-1:0] wrap(input int v);
    return IW'(v % N_REQ);
  endfunction

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_j     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_j = wrap(int'(i_ptr) + k);
      if (!o_any && i_req[w_j]) begin
        o_any        = 1'b1;
        o_grant[w_j] = 1'b1;
        o_idx        = w_j;
      end
    end
  end

endmodule

// File: rtl/matmul_scheduler.sv
// rtl/matmul_scheduler.sv - shares one row-by-matrix datapath among N_REQ requesters
// with round-robin grants, a result watchdog and a held response slot.
module matmul_scheduler
  import mm_sched_pkg::*;
#(
  parameter int W        = 16,
  parameter int IN_D     = 4,
  parameter int OUT_D    = 8,
  parameter int N_REQ    = 4,
  parameter int MAX_WAIT = 64
) (
  input  logic               clk,
  input  logic               rst,
  matmul_scheduler_if.master bus
);
  localparam int IW    = idx_width(N_REQ);
  localparam int CW    = cnt_width(MAX_WAIT);
  localparam int ROW_W = IN_D * W;
  localparam int RES_W = 2 * OUT_D * W;

  state_t             r_state;
  logic [IW-1:0]      r_ptr;
  logic [IW-1:0]      r_tag;
  logic [CW-1:0]      r_wait_cnt;
  logic [ROW_W-1:0]   r_mm_a;
  logic [RES_W-1:0]   r_resp_data;
  logic [IW-1:0]      r_resp_id;
  logic               r_resp_valid;
  logic               r_mm_start;
  logic               r_busy;
  logic               r_err;

  logic [N_REQ-1:0]   w_grant;
  logic [IW-1:0]      w_idx;
  logic               w_any;
  logic [IW-1:0]      w_ptr_next;
  logic [ROW_W-1:0]   w_rows [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_rows
    assign w_rows[g] = bus.req_a[g*ROW_W +: ROW_W];
  end

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .i_req   (bus.req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_ptr_next = (w_idx == IW'(N_REQ - 1)) ? '0 : w_idx + IW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_tag        <= '0;
      r_wait_cnt   <= '0;
      r_mm_a       <= '0;
      r_resp_data  <= '0;
      r_resp_id    <= '0;
      r_resp_valid <= 1'b0;
      r_mm_start   <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_mm_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_mm_a     <= w_rows[w_idx];
            r_tag      <= w_idx;
            r_ptr      <= w_ptr_next;
            r_mm_start <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= START;
          end
        end
        START: begin
          r_wait_cnt <= '0;
          r_state    <= WAIT;
        end
        WAIT: begin
          // A result arriving on the last allowed cycle wins over the timeout.
          if (bus.mm_out_v) begin
            r_resp_data  <= bus.mm_out;
            r_resp_id    <= r_tag;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end else if (r_wait_cnt == CW'(MAX_WAIT - 1)) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (r_state == IDLE) ? w_grant : '0;
  assign bus.mm_start   = r_mm_start;
  assign bus.mm_a       = r_mm_a;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_id    = r_resp_id;
  assign bus.busy       = r_busy;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_matmul_scheduler.sv
// tb/tb_matmul_scheduler.sv - randomized self-checking bench for matmul_scheduler
module tb_matmul_scheduler;
  localparam int W        = 16;
  localparam int IN_D     = 4;
  localparam int OUT_D    = 8;
  localparam int N_REQ    = 4;
  localparam int MAX_WAIT = 64;
  localparam int ROW_W    = IN_D * W;
  localparam int RES_W    = 2 * OUT_D * W;

  logic clk = 1'b0;
  logic rst = 1'b1;

  matmul_scheduler_if #(.W(W), .IN_D(IN_D), .OUT_D(OUT_D), .N_REQ(N_REQ)) bus ();

  matmul_scheduler #(
    .W(W), .IN_D(IN_D), .OUT_D(OUT_D), .N_REQ(N_REQ), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int n_start  = 0;
  int model_ptr = 0;

  int               dp_lat   = 5;
  bit               dp_never = 1'b0;
  int               dp_cnt   = -1;
  logic [RES_W-1:0] dp_data  = '0;

  initial forever @(posedge clk) cyc++;

  initial forever begin
    @(negedge clk);
    if (bus.mm_start === 1'b1) n_start++;
  end

  // Datapath stand-in: one-cycle result dp_lat cycles after the start pulse.
  initial begin
    bus.mm_out_v = 1'b0;
    bus.mm_out   = '0;
    forever begin
      @(negedge clk);
      bus.mm_out_v = 1'b0;
      if (bus.mm_start === 1'b1 && !dp_never) begin
        dp_cnt = dp_lat;
      end else if (dp_cnt > 0) begin
        dp_cnt--;
        if (dp_cnt == 0) begin
          for (int i = 0; i < RES_W / 32; i++) dp_data[i*32 +: 32] = $urandom();
          bus.mm_out   = dp_data;
          bus.mm_out_v = 1'b1;
        end
      end
    end
  end

  function automatic int rr_pick(input logic [N_REQ-1:0] m, input int p);
    for (int k = 0; k < N_REQ; k++)
      if (m[(p + k) % N_REQ]) return (p + k) % N_REQ;
    return -1;
  endfunction

  function automatic logic [ROW_W-1:0] row_of(input int i);
    return bus.req_a[i*ROW_W +: ROW_W];
  endfunction

  task automatic randomize_rows();
    for (int i = 0; i < N_REQ * ROW_W / 32; i++) bus.req_a[i*32 +: 32] = $urandom();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid  = '0;
    bus.resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
  endtask

  task automatic wait_grant(output int idx, output bit ok);
    ok  = 1'b0;
    idx = -1;
    for (int t = 0; t < 300 && !ok; t++) begin
      #1;
      if ((bus.req_valid & bus.req_ready) != '0) begin
        ok = 1'b1;
        for (int i = 0; i < N_REQ; i++) if (bus.req_ready[i]) idx = i;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      #1;
      if (bus.resp_valid === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid  = '0;
    bus.resp_ready = 1'b0;
    randomize_rows();
    @(negedge clk);
    #1;
    n_checks++; if (bus.req_ready !== 4'b0000) begin n_errors++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready); end
    n_checks++; if (bus.mm_start !== 1'b0) begin n_errors++; $display("FAIL reset_mm_start: got %b expected 0", bus.mm_start); end
    n_checks++; if (bus.mm_a !== '0) begin n_errors++; $display("FAIL reset_mm_a: got %h expected 0", bus.mm_a); end
    n_checks++; if (bus.resp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_resp_valid: got %b expected 0", bus.resp_valid); end
    n_checks++; if (bus.resp_data !== '0) begin n_errors++; $display("FAIL reset_resp_data: got %h expected 0", bus.resp_data); end
    n_checks++; if (bus.resp_id !== 2'd0) begin n_errors++; $display("FAIL reset_resp_id: got %0d expected 0", bus.resp_id); end
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b expected 0", bus.err); end
    @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
  endtask

  task automatic test_single();
    int st;
    bit ok;
    logic [N_REQ-1:0] exp_ready;
    logic [ROW_W-1:0] exp_row;
    do_reset();
    dp_never = 1'b0;
    dp_lat   = 5;
    randomize_rows();
    st = n_start;
    exp_ready = '0;
    exp_ready[rr_pick(4'b0100, model_ptr)] = 1'b1;
    exp_row = row_of(2);
    bus.req_valid = 4'b0100;
    #1;
    n_checks++; if (bus.req_ready !== exp_ready) begin n_errors++; $display("FAIL single_grant: got %b expected %b", bus.req_ready, exp_ready); end
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    n_checks++; if (bus.mm_start !== 1'b1 || bus.busy !== 1'b1) begin n_errors++; $display("FAIL single_start: got start=%b busy=%b expected 1 1", bus.mm_start, bus.busy); end
    n_checks++; if (bus.mm_a !== exp_row) begin n_errors++; $display("FAIL single_mm_a: got %h expected %h", bus.mm_a, exp_row); end
    n_checks++; if (bus.req_ready !== 4'b0000) begin n_errors++; $display("FAIL single_ready_busy: got %b expected 0000", bus.req_ready); end
    @(negedge clk);
    #1;
    n_checks++; if (bus.mm_start !== 1'b0) begin n_errors++; $display("FAIL single_start_pulse: got %b expected 0", bus.mm_start); end
    wait_resp(ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL single_resp_timeout: got no resp_valid expected one"); end
    n_checks++; if (bus.resp_id !== 2'd2) begin n_errors++; $display("FAIL single_resp_id: got %0d expected 2", bus.resp_id); end
    n_checks++; if (bus.resp_data !== dp_data) begin n_errors++; $display("FAIL single_resp_data: got %h expected %h", bus.resp_data, dp_data); end
    n_checks++; if (n_start - st != 1) begin n_errors++; $display("FAIL single_start_count: got %0d expected 1", n_start - st); end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    #1;
    n_checks++; if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin n_errors++; $display("FAIL single_release: got valid=%b busy=%b expected 0 0", bus.resp_valid, bus.busy); end
    bus.resp_ready = 1'b0;
    model_ptr = 3;
  endtask

  task automatic test_fairness();
    int idx, exp, last_cyc;
    bit ok;
    do_reset();
    dp_never = 1'b0;
    dp_lat   = 5;
    bus.resp_ready = 1'b1;
    bus.req_valid  = 4'b1111;
    last_cyc = 0;
    for (int g = 0; g < 5; g++) begin
      exp = rr_pick(4'b1111, model_ptr);
      wait_grant(idx, ok);
      n_checks++; if (!ok || idx != exp) begin n_errors++; $display("FAIL fair_order_%0d: got %0d expected %0d", g, idx, exp); end
      if (g > 0) begin
        n_checks++; if (cyc - last_cyc < 5) begin n_errors++; $display("FAIL fair_spacing_%0d: got %0d cycles expected >= 5", g, cyc - last_cyc); end
      end
      last_cyc  = cyc;
      model_ptr = (exp + 1) % N_REQ;
      @(negedge clk);
    end
    bus.req_valid = '0;
    for (int t = 0; t < 100 && bus.busy === 1'b1; t++) @(negedge clk);
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int idx, exp, r, st;
    bit ok;
    logic [ROW_W-1:0] exp_row;
    dp_lat = $urandom_range(2, 8);
    bus.resp_ready = 1'b0;
    randomize_rows();
    r = $urandom_range(0, N_REQ - 1);
    bus.req_valid = '0;
    bus.req_valid[r] = 1'b1;
    exp = rr_pick(bus.req_valid, model_ptr);
    exp_row = row_of(exp);
    wait_grant(idx, ok);
    n_checks++; if (!ok || idx != exp) begin n_errors++; $display("FAIL bp_grant: got %0d expected %0d", idx, exp); end
    model_ptr = (exp + 1) % N_REQ;
    @(negedge clk);
    bus.req_valid = 4'b1111;
    randomize_rows();
    wait_resp(ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL bp_resp_timeout: got no resp_valid expected one"); end
    st = n_start;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_data !== dp_data || int'(bus.resp_id) != exp ||
          bus.req_ready !== 4'b0000 || bus.mm_a !== exp_row) begin
        n_errors++;
        $display("FAIL bp_hold_%0d: got valid=%b id=%0d ready=%b data_ok=%b row_ok=%b expected 1 %0d 0000 1 1",
                 c, bus.resp_valid, bus.resp_id, bus.req_ready, bus.resp_data === dp_data, bus.mm_a === exp_row, exp);
      end
    end
    n_checks++; if (n_start != st) begin n_errors++; $display("FAIL bp_no_start: got %0d extra starts expected 0", n_start - st); end
    bus.req_valid  = '0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    #1;
    n_checks++; if (bus.resp_valid !== 1'b0) begin n_errors++; $display("FAIL bp_release: got %b expected 0", bus.resp_valid); end
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_timeout();
    int idx, exp, r;
    bit ok, saw_resp;
    do_reset();
    dp_never = 1'b1;
    bus.resp_ready = 1'b1;
    r = $urandom_range(0, N_REQ - 1);
    bus.req_valid = '0;
    bus.req_valid[r] = 1'b1;
    exp = rr_pick(bus.req_valid, model_ptr);
    wait_grant(idx, ok);
    n_checks++; if (!ok || idx != exp) begin n_errors++; $display("FAIL to_grant: got %0d expected %0d", idx, exp); end
    model_ptr = (exp + 1) % N_REQ;
    @(negedge clk);
    bus.req_valid = '0;
    saw_resp = 1'b0;
    // k counts cycles after the grant: START is k=1, WAIT spans k=2..MAX_WAIT+1.
    for (int k = 1; k <= MAX_WAIT + 2; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      if (bus.resp_valid === 1'b1) saw_resp = 1'b1;
      if (k == MAX_WAIT + 1) begin
        n_checks++; if (bus.err !== 1'b0 || bus.busy !== 1'b1) begin n_errors++; $display("FAIL to_last_wait: got err=%b busy=%b expected 0 1", bus.err, bus.busy); end
      end
      if (k == MAX_WAIT + 2) begin
        n_checks++; if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin n_errors++; $display("FAIL to_expired: got err=%b busy=%b expected 1 0", bus.err, bus.busy); end
      end
    end
    n_checks++; if (saw_resp) begin n_errors++; $display("FAIL to_no_resp: got resp_valid expected none"); end
    dp_never = 1'b0;
    dp_lat   = $urandom_range(2, 8);
    randomize_rows();
    r = $urandom_range(0, N_REQ - 1);
    bus.req_valid[r] = 1'b1;
    exp = rr_pick(bus.req_valid, model_ptr);
    wait_grant(idx, ok);
    n_checks++; if (!ok || idx != exp) begin n_errors++; $display("FAIL to_next_grant: got %0d expected %0d", idx, exp); end
    model_ptr = (exp + 1) % N_REQ;
    @(negedge clk);
    bus.req_valid = '0;
    wait_resp(ok);
    n_checks++; if (!ok || bus.resp_data !== dp_data || int'(bus.resp_id) != exp) begin n_errors++; $display("FAIL to_next_resp: got ok=%b id=%0d expected 1 %0d", ok, bus.resp_id, exp); end
    n_checks++; if (bus.err !== 1'b1) begin n_errors++; $display("FAIL to_err_sticky: got %b expected 1", bus.err); end
    @(negedge clk);
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_simultaneous();
    int idx, exp;
    bit ok;
    do_reset();
    #1;
    n_checks++; if (bus.err !== 1'b0) begin n_errors++; $display("FAIL sim_err_cleared: got %b expected 0", bus.err); end
    dp_never = 1'b0;
    dp_lat   = MAX_WAIT;
    bus.resp_ready = 1'b1;
    bus.req_valid  = 4'b1010;
    exp = rr_pick(4'b1010, model_ptr);
    wait_grant(idx, ok);
    n_checks++; if (!ok || idx != exp) begin n_errors++; $display("FAIL sim_grant: got %0d expected %0d", idx, exp); end
    model_ptr = (exp + 1) % N_REQ;
    @(negedge clk);
    bus.req_valid = '0;
    wait_resp(ok);
    n_checks++; if (!ok || bus.resp_data !== dp_data || int'(bus.resp_id) != exp) begin n_errors++; $display("FAIL sim_resp: got ok=%b id=%0d expected 1 %0d", ok, bus.resp_id, exp); end
    n_checks++; if (bus.err !== 1'b0) begin n_errors++; $display("FAIL sim_err: got %b expected 0", bus.err); end
    @(negedge clk);
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int idx, st;
    bit ok, saw;
    do_reset();
    dp_never = 1'b0;
    dp_lat   = 8;
    randomize_rows();
    bus.req_valid = 4'b0010;
    wait_grant(idx, ok);
    @(negedge clk);
    bus.req_valid = '0;
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.mm_a !== '0 || bus.mm_start !== 1'b0 || bus.resp_valid !== 1'b0 ||
        bus.resp_data !== '0 || bus.resp_id !== 2'd0 || bus.err !== 1'b0) begin
      n_errors++;
      $display("FAIL mid_async_reset: got busy=%b start=%b valid=%b err=%b id=%0d expected all 0",
               bus.busy, bus.mm_start, bus.resp_valid, bus.err, bus.resp_id);
    end
    @(negedge clk);
    rst = 1'b0;
    model_ptr = 0;
    st  = n_start;
    saw = 1'b0;
    bus.resp_ready = 1'b1;
    repeat (15) begin
      @(negedge clk);
      #1;
      if (bus.resp_valid === 1'b1 || bus.busy === 1'b1) saw = 1'b1;
    end
    n_checks++; if (saw) begin n_errors++; $display("FAIL mid_late_result: got activity after reset expected none"); end
    n_checks++; if (n_start != st) begin n_errors++; $display("FAIL mid_no_start: got %0d starts expected 0", n_start - st); end
    bus.resp_ready = 1'b0;
  endtask

  task automatic test_random();
    int idx, exp;
    bit ok;
    logic [N_REQ-1:0] mask;
    logic [ROW_W-1:0] exp_row;
    dp_never = 1'b0;
    for (int n = 0; n < 20; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      bus.resp_ready = 1'b0;
      dp_lat = $urandom_range(2, 12);
      randomize_rows();
      mask = 4'($urandom_range(1, 15));
      exp  = rr_pick(mask, model_ptr);
      exp_row = row_of(exp);
      bus.req_valid = mask;
      wait_grant(idx, ok);
      n_checks++; if (!ok || idx != exp) begin n_errors++; $display("FAIL rnd_grant_%0d: got %0d expected %0d mask %b", n, idx, exp, mask); end
      model_ptr = (exp + 1) % N_REQ;
      @(negedge clk);
      bus.req_valid = '0;
      #1;
      n_checks++; if (bus.mm_a !== exp_row) begin n_errors++; $display("FAIL rnd_row_%0d: got %h expected %h", n, bus.mm_a, exp_row); end
      wait_resp(ok);
      n_checks++;
      if (!ok || bus.resp_data !== dp_data || int'(bus.resp_id) != exp) begin
        n_errors++;
        $display("FAIL rnd_resp_%0d: got ok=%b id=%0d expected 1 %0d", n, ok, bus.resp_id, exp);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      bus.resp_ready = 1'b1;
      @(negedge clk);
      #1;
      n_checks++; if (bus.resp_valid !== 1'b0) begin n_errors++; $display("FAIL rnd_release_%0d: got %b expected 0", n, bus.resp_valid); end
      bus.resp_ready = 1'b0;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.req_valid  = '0;
    bus.resp_ready = 1'b0;
    bus.req_a      = '0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_timeout();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
